// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks an 8-bit byte-addressed ROM one word at a time
// into a 2-entry {pc, word} buffer, with redirect, halt-word stop and misalignment trap.
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  input  logic        br_valid,
  input  logic [7:0]  br_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [7:0]  inst_pc,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state   | meaning
  // S_IDLE  | waiting for start or redirect
  // S_RUN   | fetching while the buffer has room
  // S_DONE  | halt word fetched, buffer drains
  // S_ERROR | misaligned redirect, held until reset
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [31:0] e0_word_q, e0_word_d, e1_word_q, e1_word_d;

  logic       xfer;
  logic       redirect;
  logic       br_aligned;
  logic       restart;
  logic       fetch;
  logic [1:0] cnt_pop;

  assign inst_valid = (cnt_q != 2'd0) && (state_q != S_ERROR);
  assign inst       = inst_valid ? e0_word_q : 32'h0;
  assign inst_pc    = inst_valid ? e0_pc_q : 8'h00;
  assign rom_addr   = pc_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);

  assign xfer       = inst_valid && inst_ready;
  assign redirect   = br_valid && (state_q != S_ERROR);
  assign br_aligned = (br_target[1:0] == 2'b00);
  assign restart    = start && !redirect && ((state_q == S_IDLE) || (state_q == S_DONE));
  // A full buffer can still accept a fetch when the head leaves on the same edge.
  assign fetch      = (state_q == S_RUN) && !redirect && ((cnt_q != 2'd2) || xfer);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    e0_pc_d   = e0_pc_q;
    e0_word_d = e0_word_q;
    e1_pc_d   = e1_pc_q;
    e1_word_d = e1_word_q;
    cnt_pop   = cnt_q - {1'b0, xfer};
    cnt_d     = cnt_pop;

    if (xfer) begin
      e0_pc_d   = e1_pc_q;
      e0_word_d = e1_word_q;
    end

    if (fetch) begin
      if (cnt_pop == 2'd0) begin
        e0_pc_d   = pc_q;
        e0_word_d = rom_data;
      end else begin
        e1_pc_d   = pc_q;
        e1_word_d = rom_data;
      end
      cnt_d = cnt_pop + 2'd1;
      pc_d  = pc_q + 8'd4;
      if (rom_data == HALT_WORD) begin
        state_d = S_DONE;
      end
    end

    // Redirect outranks start; a misaligned target traps with pc held.
    if (redirect) begin
      cnt_d = 2'd0;
      if (br_aligned) begin
        pc_d    = br_target;
        state_d = S_RUN;
      end else begin
        pc_d    = pc_q;
        state_d = S_ERROR;
      end
    end else if (restart) begin
      cnt_d   = 2'd0;
      pc_d    = RESET_PC;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      cnt_q     <= 2'd0;
      e0_pc_q   <= 8'h00;
      e0_word_q <= 32'h0;
      e1_pc_q   <= 8'h00;
      e1_word_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      e0_pc_q   <= e0_pc_d;
      e0_word_q <= e0_word_d;
      e1_pc_q   <= e1_pc_d;
      e1_word_q <= e1_word_d;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 8'h00, is the byte address of the first fetch after reset or start.
REQ-003 Parameter HALT_WORD, default 32'h0000_0000, is the instruction word that ends fetching.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse; begins fetching from RESET_PC.
REQ-007 rom_addr  output  8  byte address driven to the instruction ROM A port.
REQ-008 rom_data  input  32  big-endian word returned combinationally by the ROM for rom_addr.
REQ-009 br_valid  input  1  redirect request.
REQ-010 br_target  input  8  redirect byte address.
REQ-011 inst_valid  output  1  head buffer entry is valid.
REQ-012 inst_ready  input  1  consumer accepts the head entry.
REQ-013 inst  output  32  head instruction word.
REQ-014 inst_pc  output  8  byte address of the head instruction.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 err  output  1  high in ERROR.

Function
REQ-018 FSM states: IDLE, RUN, DONE, ERROR. Encoding is free.
REQ-019 Register pc (8 bits) SHALL drive rom_addr directly; rom_addr SHALL be combinationally independent of rom_data.
REQ-020 Buffer: 2-entry FIFO of {pc, word}; inst, inst_pc and inst_valid SHALL come from the head entry; with the buffer empty, inst = 0 and inst_pc = 0.
REQ-021 Transfer occurs on a rising edge with inst_valid=1 and inst_ready=1; the head entry SHALL then be popped.
REQ-022 Fetch occurs in RUN on an edge where (count<2, or a transfer occurs), and no redirect is taken; it SHALL push {pc, rom_data} and set pc <= pc+4 mod 256, with 8'hFC wrapping to 8'h00.
REQ-023 A back-to-back consumer SHALL see one instruction per cycle; the first inst_valid occurs 1 cycle after the start edge.
REQ-024 IDLE: start=1 SHALL set pc <= RESET_PC and move to RUN; no fetch occurs on that edge.
REQ-025 RUN: if a fetched word equals HALT_WORD, it SHALL still be pushed, and the state SHALL move to DONE; no further fetches occur.
REQ-026 DONE: the buffer SHALL keep draining through normal transfers; start=1 SHALL restart as in REQ-024 and flush the buffer.
REQ-027 Redirect (br_valid=1) in RUN, DONE or IDLE with br_target[1:0]==0: any transfer on that edge SHALL complete; all remaining entries SHALL be flushed; pc <= br_target; state SHALL become RUN; no fetch occurs on that edge.
REQ-028 Redirect with br_target[1:0]!=0: the buffer SHALL flush, pc SHALL be held, and the state SHALL become ERROR.
REQ-029 ERROR SHALL persist until reset; start and br_valid SHALL be ignored, and inst_valid=0.
REQ-030 Simultaneous br_valid and start: br_valid SHALL win; start in RUN SHALL be ignored.
REQ-031 The FIFO SHALL never overflow: no push when count==2 without a transfer; a pop on empty cannot occur.

Reset
REQ-032 When rst_n=0, the block SHALL set state=IDLE, pc=RESET_PC, count=0, rom_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, busy=0, done=0, err=0.
REQ-033 Reset applies immediately, including mid-fetch or mid-transfer; the buffer contents SHALL be discarded.
REQ-034 The first active edge after rst_n rises SHALL see state IDLE.

Verification
REQ-035 ROM bytes 00..0F = 01..10 (word3 nonzero), inst_ready=1 held, start pulse -> inst_pc 00,04,08,0C on consecutive cycles with inst 01020304, 05060708, 090A0B0C, 0D0E0F10.
REQ-036 inst_ready=0 for 5 cycles after start -> count saturates at 2, rom_addr holds 08, and inst stays 01020304; releasing inst_ready -> 00,04,08 delivered on consecutive cycles with no bubble.
REQ-037 Word at 08 = 00000000 -> entries 00,04,08 delivered, done=1, rom_addr frozen at 0C, busy=0.
REQ-038 br_valid with target 8'h40 while 2 entries are buffered and inst_ready=1 -> the head entry transfers, the other entry is dropped, and the next inst_pc is 40.
REQ-039 br_valid with target 8'h42 -> err=1 and inst_valid=0; a following start is ignored; rst_n pulse -> IDLE with all outputs at reset values.
REQ-040 Fetch running from FC with inst_ready=1 -> inst_pc FC followed by 00; rst_n asserted mid-stream -> inst_valid drops to 0 without waiting for a clock edge.
